// File: rtl/BiSet.sv
// BiSet settings-bus definitions shared by initiators and targets.
package BiSet;
  localparam int BISET_DATALEN = 32;
  localparam int BISET_ADDRLEN = 8;

  typedef struct packed {
    logic                     en;
    logic                     we;
    logic [BISET_ADDRLEN-1:0] addr;
  } biSetCtrl;

  typedef logic [BISET_DATALEN-1:0] biSetData;

  typedef struct packed {
    logic                     ack;
    logic                     err;
    logic [BISET_DATALEN-1:0] data;
  } biSetReply;
endpackage

// File: rtl/biset_reg_target.sv
// BiSet leaf target: NREG RW config registers, a W1C status register and a read-only ID.
// Define BISET_TGT_LOCK_EN to add a LOCK register at NREG+2 that blocks config writes.
module biset_reg_target #(
  parameter int                               NREG      = 4,
  parameter logic [31:0]                      ID_VALUE  = 32'h0,
  parameter logic [BiSet::BISET_DATALEN-1:0]  CFG_RESET = '0
) (
  input  logic                                   clk_i,
  input  logic                                   rst_ni,
  input  BiSet::biSetCtrl                        ctrl_i,
  input  BiSet::biSetData                        write_i,
  output BiSet::biSetReply                       reply_o,
  output logic [NREG*BiSet::BISET_DATALEN-1:0]   cfg_o,
  output logic [NREG-1:0]                        cfg_wr_o,
  input  logic [BiSet::BISET_DATALEN-1:0]        status_i,
  output logic                                   irq_o
);
  localparam int DATA_W = BiSet::BISET_DATALEN;
  localparam logic [31:0] ADDR_STATUS = 32'(NREG);
  localparam logic [31:0] ADDR_ID     = 32'(NREG + 1);

  logic [DATA_W-1:0] cfg_q [NREG];
  logic [DATA_W-1:0] status_q;
  logic [DATA_W-1:0] status_clr;
  logic [DATA_W-1:0] cfg_rdata;
  logic [NREG-1:0]   cfg_we;
  logic [NREG-1:0]   cfg_wr_p1;
  BiSet::biSetReply  reply_d;
  BiSet::biSetReply  reply_p1;
  logic [31:0]       addr;
  logic              is_cfg;
  logic              locked;

  // Full-width zero extension so out-of-range indices never alias onto real registers.
  assign addr   = 32'(ctrl_i.addr);
  assign is_cfg = (addr < ADDR_STATUS);

`ifdef BISET_TGT_LOCK_EN
  localparam logic [31:0] ADDR_LOCK = 32'(NREG + 2);
  logic lock_q;
  logic lock_we;
  assign locked  = lock_q;
  assign lock_we = ctrl_i.en && ctrl_i.we && (addr == ADDR_LOCK);

  always_ff @(posedge clk_i) begin
    if (!rst_ni)      lock_q <= 1'b0;
    else if (lock_we) lock_q <= write_i[0];
  end
`else
  assign locked = 1'b0;
`endif

  // Stage p0: decode the request and form the reply from pre-update register values
  always_comb begin
    cfg_rdata = '0;
    for (int k = 0; k < NREG; k++) begin
      if (addr == 32'(k)) cfg_rdata = cfg_q[k];
    end
  end

  always_comb begin
    reply_d    = '0;
    cfg_we     = '0;
    status_clr = '0;
    if (ctrl_i.en) begin
      reply_d.ack = 1'b1;
      if (ctrl_i.we) begin
        if (is_cfg && !locked) begin
          for (int k = 0; k < NREG; k++) begin
            if (addr == 32'(k)) cfg_we[k] = 1'b1;
          end
        end else if (addr == ADDR_STATUS) begin
          status_clr = write_i;
`ifdef BISET_TGT_LOCK_EN
        end else if (addr == ADDR_LOCK) begin
          reply_d.err = 1'b0;
`endif
        end else begin
          reply_d.err = 1'b1;
        end
      end else begin
        if (is_cfg) begin
          reply_d.data = cfg_rdata;
        end else if (addr == ADDR_STATUS) begin
          reply_d.data = status_q;
        end else if (addr == ADDR_ID) begin
          reply_d.data = DATA_W'(ID_VALUE);
`ifdef BISET_TGT_LOCK_EN
        end else if (addr == ADDR_LOCK) begin
          reply_d.data = DATA_W'(lock_q);
`endif
        end else begin
          reply_d.err = 1'b1;
        end
      end
    end
  end

  // Stage p1: registered reply, strobes and register state
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      reply_p1  <= '0;
      cfg_wr_p1 <= '0;
      status_q  <= '0;
      for (int k = 0; k < NREG; k++) cfg_q[k] <= CFG_RESET;
    end else begin
      reply_p1  <= reply_d;
      cfg_wr_p1 <= cfg_we;
      // Event set takes priority over a same-cycle W1C clear.
      status_q  <= (status_q & ~status_clr) | status_i;
      for (int k = 0; k < NREG; k++) begin
        if (cfg_we[k]) cfg_q[k] <= write_i;
      end
    end
  end

  for (genvar g = 0; g < NREG; g++) begin : g_cfg_out
    assign cfg_o[g*DATA_W +: DATA_W] = cfg_q[g];
  end

  assign reply_o  = reply_p1;
  assign cfg_wr_o = cfg_wr_p1;
  assign irq_o    = |status_q;
endmodule

// File: tb/tb_biset_reg_target.sv
// Bench for biset_reg_target: directed vector table plus randomized traffic against a register-map model.
module tb_biset_reg_target;
  localparam int          NREG = 4;
  localparam int          DW   = BiSet::BISET_DATALEN;
  localparam int          AW   = BiSet::BISET_ADDRLEN;
  localparam logic [31:0] ID   = 32'hB15E_7A61;
  localparam logic [31:0] CRST = 32'h0000_1234;
`ifdef BISET_TGT_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst_n;
  BiSet::biSetCtrl    ctrl;
  BiSet::biSetData    wdata;
  BiSet::biSetReply   reply;
  logic [NREG*DW-1:0] cfg;
  logic [NREG-1:0]    cfg_wr;
  logic [DW-1:0]      status;
  logic               irq;

  always #5 clk = ~clk;

  biset_reg_target #(.NREG(NREG), .ID_VALUE(ID), .CFG_RESET(CRST)) dut (
    .clk_i(clk), .rst_ni(rst_n), .ctrl_i(ctrl), .write_i(wdata), .reply_o(reply),
    .cfg_o(cfg), .cfg_wr_o(cfg_wr), .status_i(status), .irq_o(irq)
  );

  // Register-map model state
  logic [DW-1:0] m_cfg [NREG];
  logic [DW-1:0] m_status;
  logic          m_lock;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input logic rn, input logic en, input logic we, input logic [AW-1:0] ad,
                      input logic [DW-1:0] wd, input logic [DW-1:0] st, output BiSet::biSetReply got);
    BiSet::biSetReply   er;
    logic [NREG-1:0]    ew;
    logic [DW-1:0]      ncfg [NREG];
    logic [DW-1:0]      nstat;
    logic [DW-1:0]      clr;
    logic               nlock;
    logic [NREG*DW-1:0] ecfg;
    int unsigned        a;
    rst_n = rn; ctrl.en = en; ctrl.we = we; ctrl.addr = ad; wdata = wd; status = st;
    er = '0; ew = '0; ncfg = m_cfg; clr = '0; nlock = m_lock; nstat = m_status; a = ad;
    if (!rn) begin
      foreach (ncfg[k]) ncfg[k] = CRST;
      nstat = '0;
      nlock = 1'b0;
    end else begin
      if (en) begin
        er.ack = 1'b1;
        if (we) begin
          if (a < NREG) begin
            if (m_lock) er.err = 1'b1;
            else begin ncfg[a] = wd; ew[a] = 1'b1; end
          end else if (a == NREG) clr = wd;
          else if (LOCK_EN && a == NREG + 2) nlock = wd[0];
          else er.err = 1'b1;
        end else begin
          if (a < NREG) er.data = m_cfg[a];
          else if (a == NREG) er.data = m_status;
          else if (a == NREG + 1) er.data = ID;
          else if (LOCK_EN && a == NREG + 2) er.data = DW'(m_lock);
          else er.err = 1'b1;
        end
      end
      nstat = (m_status & ~clr) | st;
    end
    for (int k = 0; k < NREG; k++) ecfg[k*DW +: DW] = ncfg[k];
    @(posedge clk);
    #1;
    check("reply", 64'(reply), 64'(er));
    check("cfg_wr", 64'(cfg_wr), 64'(ew));
    check("cfg", 64'(cfg), 64'(ecfg));
    check("irq", 64'(irq), 64'(|nstat));
    m_cfg = ncfg; m_status = nstat; m_lock = nlock;
    got = reply;
  endtask

  typedef struct {
    logic          rn, en, we;
    logic [AW-1:0] ad;
    logic [DW-1:0] wd, st;
    logic          ack, err;
    logic [DW-1:0] data;
  } vec_t;

  function automatic vec_t v(logic rn, logic en, logic we, int ad, logic [DW-1:0] wd,
                             logic [DW-1:0] st, logic ack, logic err, logic [DW-1:0] data);
    vec_t r;
    r.rn = rn; r.en = en; r.we = we; r.ad = AW'(ad); r.wd = wd; r.st = st;
    r.ack = ack; r.err = err; r.data = data;
    return r;
  endfunction

  vec_t tbl[$];
  BiSet::biSetReply got;

  initial begin
    m_status = '0; m_lock = 1'b0;
    foreach (m_cfg[k]) m_cfg[k] = '0;
    rst_n = 1'b0; ctrl = '0; wdata = '0; status = '0;

    // Reset / idle / ID / back-to-back write-read
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(1, 1, 0, 0, 0, 0, 1, 0, CRST));
    tbl.push_back(v(1, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(1, 1, 0, NREG + 1, 0, 0, 1, 0, ID));
    tbl.push_back(v(1, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(1, 1, 1, 1, 32'hA5, 0, 1, 0, 0));
    tbl.push_back(v(1, 1, 0, 1, 0, 0, 1, 0, 32'hA5));
    // Status: set, set-beats-clear, clear each bit
    tbl.push_back(v(1, 0, 0, 0, 0, 32'h5, 0, 0, 0));
    tbl.push_back(v(1, 1, 0, NREG, 0, 0, 1, 0, 32'h5));
    tbl.push_back(v(1, 1, 1, NREG, 32'h1, 32'h1, 1, 0, 0));
    tbl.push_back(v(1, 1, 0, NREG, 0, 0, 1, 0, 32'h5));
    tbl.push_back(v(1, 1, 1, NREG, 32'h1, 0, 1, 0, 0));
    tbl.push_back(v(1, 1, 0, NREG, 0, 0, 1, 0, 32'h4));
    tbl.push_back(v(1, 1, 1, NREG, 32'h4, 0, 1, 0, 0));
    tbl.push_back(v(1, 1, 0, NREG, 0, 0, 1, 0, 32'h0));
    // Error responses and no aliasing of high addresses
    tbl.push_back(v(1, 1, 1, NREG + 1, 32'hFFFF, 0, 1, 1, 0));
    tbl.push_back(v(1, 1, 0, NREG + 3, 0, 0, 1, 1, 0));
    tbl.push_back(v(1, 1, 1, 255, 32'h77, 0, 1, 1, 0));
    tbl.push_back(v(1, 1, 0, 255, 0, 0, 1, 1, 0));
    tbl.push_back(v(1, 1, 0, NREG + 1, 0, 0, 1, 0, ID));
    tbl.push_back(v(1, 1, 0, 1, 0, 0, 1, 0, 32'hA5));
`ifdef BISET_TGT_LOCK_EN
    tbl.push_back(v(1, 1, 1, NREG + 2, 32'h1, 0, 1, 0, 0));
    tbl.push_back(v(1, 1, 0, NREG + 2, 0, 0, 1, 0, 32'h1));
    tbl.push_back(v(1, 1, 1, 0, 32'h3C, 0, 1, 1, 0));
    tbl.push_back(v(1, 1, 0, 0, 0, 0, 1, 0, CRST));
    tbl.push_back(v(1, 1, 1, NREG + 2, 32'h0, 0, 1, 0, 0));
    tbl.push_back(v(1, 1, 1, 0, 32'h3C, 0, 1, 0, 0));
    tbl.push_back(v(1, 1, 0, 0, 0, 0, 1, 0, 32'h3C));
    tbl.push_back(v(1, 1, 0, NREG + 2, 0, 0, 1, 0, 32'h0));
`else
    tbl.push_back(v(1, 1, 0, NREG + 2, 0, 0, 1, 1, 0));
    tbl.push_back(v(1, 1, 1, NREG + 2, 32'h1, 0, 1, 1, 0));
`endif
    // Reset mid-operation drops the pending reply and clears the lock
    tbl.push_back(v(1, 1, 1, 2, 32'h77, 0, 1, 0, 0));
    tbl.push_back(v(1, 1, 1, NREG + 2, 32'h1, 0, 1, !LOCK_EN, 0));
    tbl.push_back(v(0, 1, 0, 2, 0, 32'h3, 0, 0, 0));
    tbl.push_back(v(1, 1, 1, 0, 32'h3C, 0, 1, 0, 0));
    tbl.push_back(v(1, 1, 0, 0, 0, 0, 1, 0, 32'h3C));
    tbl.push_back(v(1, 1, 0, 2, 0, 0, 1, 0, CRST));
    tbl.push_back(v(1, 0, 0, 0, 0, 0, 0, 0, 0));

    foreach (tbl[i]) begin
      step(tbl[i].rn, tbl[i].en, tbl[i].we, tbl[i].ad, tbl[i].wd, tbl[i].st, got);
      check($sformatf("vec%0d_reply", i), 64'(got), 64'({tbl[i].ack, tbl[i].err, tbl[i].data}));
    end

    for (int i = 0; i < 400; i++) begin
      logic          rn, en, we;
      logic [AW-1:0] ad;
      logic [DW-1:0] wd, st;
      rn = ($urandom_range(0, 39) != 0);
      en = ($urandom_range(0, 3) != 0);
      we = $urandom_range(0, 1) == 1;
      ad = ($urandom_range(0, 9) == 0) ? AW'($urandom) : AW'($urandom_range(0, NREG + 3));
      wd = ($urandom_range(0, 3) == 0) ? DW'($urandom_range(0, 1)) : DW'($urandom);
      st = ($urandom_range(0, 5) == 0) ? DW'($urandom_range(0, 15)) : '0;
      step(rn, en, we, ad, wd, st, got);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
